mm_dispatch: RTL and testbench
==============================

MM_DISPATCH -- requirements
Module: mm_dispatch

Interface
REQ-001 The block SHALL have parameter OPCODE_MM, default 4'h2: the opcode value accepted as a matrix-multiply instruction.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 24'hFFFFFF: the BUSY-cycle limit before a timeout (used only with MM_DISPATCH_TIMEOUT_EN).
REQ-003 The block SHALL have these ports:
 clk  in  1  single clock, all logic on rising edge
 rstn  in  1  reset, asynchronous, active-low
 instr_valid  in  1  instruction offered
 instr_ready  out  1  instruction may be accepted
 instr_data  in  128  packed instruction
 start_valid  out  1  one-cycle start pulse to the matrix-multiply engine
 weight_start_addr  out  13  field [16:4]
 input_start_addr  out  11  field [27:17]
 output_start_addr  out  11  field [38:28]
 input_addr_per_feature  out  8  Ci, field [46:39]
 output_addr_per_feature  out  8  Co, field [54:47]
 number_of_node  out  16  N, field [70:55]
 bias_start_addr  out  9  field [79:71]
 r  out  1  relu enable, bit [80]
 a  out  1  accumulate enable, bit [81]
 b  out  1  bias enable, bit [82]
 done  in  1  engine completion pulse
 busy  out  1  high in any state other than IDLE
 cmpl_valid  out  1  one-cycle completion pulse
 cmpl_status  out  2  00 ok, 01 rejected, 10 timeout
REQ-004 The block SHALL treat opcode as instr_data[3:0] and ignore instr_data[127:83].

Function
REQ-005 The block SHALL implement states IDLE, START, BUSY, CMPL, HALT.
REQ-006 The block SHALL drive instr_ready=1 only in IDLE; an instruction SHALL be accepted on a cycle with instr_valid=1 and instr_ready=1.
REQ-007 On accept, all parameter outputs SHALL register the instruction fields at the next edge and SHALL hold them unchanged until the next accept.
REQ-008 A valid accepted instruction (opcode==OPCODE_MM, Ci!=0, Co!=0, N!=0) SHALL move IDLE->START; start_valid SHALL be 1 only in START, exactly one cycle, one cycle after the accept cycle.
REQ-009 START SHALL move unconditionally to BUSY; a done sampled in START SHALL be ignored.
REQ-010 BUSY SHALL move to CMPL on the first cycle done=1 is sampled, with cmpl_status=00.
REQ-011 An accepted instruction with opcode mismatch, or any of Ci, Co, N equal to zero, SHALL move IDLE->CMPL with cmpl_status=01 and SHALL NOT pulse start_valid.
REQ-012 cmpl_valid SHALL be 1 only in CMPL, exactly one cycle; CMPL SHALL return to IDLE; cmpl_status SHALL hold its value until the next CMPL.
REQ-013 The minimum dispatch-to-dispatch spacing SHALL be: accept at T, start_valid at T+1, done at D, cmpl_valid at D+1, next accept possible at D+2.
REQ-014 done received in IDLE, CMPL or HALT SHALL be ignored and SHALL NOT change state.
REQ-015 busy SHALL be 0 in IDLE and 1 in START, BUSY, CMPL and HALT.

Reset
REQ-016 rstn=0 SHALL immediately force state IDLE, start_valid=0, cmpl_valid=0, cmpl_status=00, busy=0, all parameter outputs=0, and the timeout counter=0, including mid-operation.
REQ-017 instr_ready SHALL be 0 while rstn=0 and SHALL be 1 from the first clock edge after rstn deasserts.

Configuration
REQ-018 With macro MM_DISPATCH_TIMEOUT_EN defined, a 24-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without done.
REQ-019 With MM_DISPATCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES in BUSY and done=0, the block SHALL pulse cmpl_valid with cmpl_status=10 and enter HALT.
REQ-020 HALT SHALL hold instr_ready=0 until reset.
REQ-021 With MM_DISPATCH_TIMEOUT_EN undefined, no counter SHALL exist, HALT SHALL be unreachable, BUSY SHALL wait for done indefinitely, and status 10 SHALL never be produced.

Verification
REQ-022 The bench SHALL cover: Ci=4, Co=2, N=3, opcode 2, valid at T -> start_valid only at T+1, fields stable, done at T+30 -> cmpl_valid at T+31 with status 00, instr_ready=1 at T+32.
REQ-023 The bench SHALL cover: opcode 4'h5 -> no start_valid, cmpl_valid at T+1 with status 01; repeat with N=0 -> same response.
REQ-024 The bench SHALL cover: instr_valid held high during BUSY with new fields -> not accepted, outputs unchanged, taken only after return to IDLE.
REQ-025 The bench SHALL cover: done pulsed in IDLE and in START -> no state change; rstn low in BUSY -> all outputs 0 immediately, instr_ready=1 after release.
REQ-026 The bench SHALL cover: with MM_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done -> status 10 after 16 BUSY cycles, instr_ready stays 0 until reset.

Source files
------------

// File: rtl/mm_dispatch.sv
// rtl/mm_dispatch.sv - matrix-multiply instruction dispatcher; optional BUSY timeout under MM_DISPATCH_TIMEOUT_EN
module mm_dispatch #(
    parameter logic [3:0]  OPCODE_MM      = 4'h2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [127:0] instr_data,
    output logic         start_valid,
    output logic [12:0]  weight_start_addr,
    output logic [10:0]  input_start_addr,
    output logic [10:0]  output_start_addr,
    output logic [7:0]   input_addr_per_feature,
    output logic [7:0]   output_addr_per_feature,
    output logic [15:0]  number_of_node,
    output logic [8:0]   bias_start_addr,
    output logic         r,
    output logic         a,
    output logic         b,
    input  logic         done,
    output logic         busy,
    output logic         cmpl_valid,
    output logic [1:0]   cmpl_status
);

    typedef enum logic [2:0] {IDLE, START, BUSY, CMPL, HALT} state_t;

    state_t      state_q, state_d;
    logic [78:0] param_q, param_d;
    logic [1:0]  status_q, status_d;
    logic        start_valid_q, start_valid_d;
    logic        cmpl_valid_q, cmpl_valid_d;
    logic        busy_q, busy_d;
    logic        instr_ready_q, instr_ready_d;
    logic        accept, instr_ok, timeout;

`ifdef MM_DISPATCH_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;
    wire unused_hi = ^instr_data[127:83];
`else
    wire unused_hi = ^{instr_data[127:83], TIMEOUT_CYCLES};
`endif

    assign accept   = instr_valid && instr_ready_q;
    assign instr_ok = (instr_data[3:0] == OPCODE_MM) && (|instr_data[46:39])
                   && (|instr_data[54:47]) && (|instr_data[70:55]);

    always_comb begin
        state_d  = state_q;
        param_d  = param_q;
        status_d = status_q;
        timeout  = 1'b0;
`ifdef MM_DISPATCH_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    param_d = instr_data[82:4];
                    if (instr_ok) begin
                        state_d = START;
                    end else begin
                        state_d  = CMPL;
                        status_d = 2'b01;
                    end
                end
            end
            START: begin
                state_d = BUSY;
`ifdef MM_DISPATCH_TIMEOUT_EN
                cnt_d   = 24'd0;
`endif
            end
            BUSY: begin
                if (done) begin
                    state_d  = CMPL;
                    status_d = 2'b00;
                end else begin
`ifdef MM_DISPATCH_TIMEOUT_EN
                    // cnt_d counts BUSY cycles without done, including this one
                    cnt_d = cnt_q + 24'd1;
                    if (cnt_d == TIMEOUT_CYCLES) begin
                        state_d  = HALT;
                        status_d = 2'b10;
                        timeout  = 1'b1;
                    end
`endif
                end
            end
            CMPL:    state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        start_valid_d = (state_d == START);
        cmpl_valid_d  = (state_d == CMPL) || timeout;
        busy_d        = (state_d != IDLE);
        instr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            param_q       <= '0;
            status_q      <= 2'b00;
            start_valid_q <= 1'b0;
            cmpl_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            instr_ready_q <= 1'b0;
`ifdef MM_DISPATCH_TIMEOUT_EN
            cnt_q         <= 24'd0;
`endif
        end else begin
            state_q       <= state_d;
            param_q       <= param_d;
            status_q      <= status_d;
            start_valid_q <= start_valid_d;
            cmpl_valid_q  <= cmpl_valid_d;
            busy_q        <= busy_d;
            instr_ready_q <= instr_ready_d;
`ifdef MM_DISPATCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    // param_q holds instr_data[82:4]; bit 0 here is instruction bit 4
    assign weight_start_addr       = param_q[12:0];
    assign input_start_addr        = param_q[23:13];
    assign output_start_addr       = param_q[34:24];
    assign input_addr_per_feature  = param_q[42:35];
    assign output_addr_per_feature = param_q[50:43];
    assign number_of_node          = param_q[66:51];
    assign bias_start_addr         = param_q[75:67];
    assign r                       = param_q[76];
    assign a                       = param_q[77];
    assign b                       = param_q[78];
    assign start_valid             = start_valid_q;
    assign cmpl_valid              = cmpl_valid_q;
    assign cmpl_status             = status_q;
    assign busy                    = busy_q;
    assign instr_ready             = instr_ready_q;

endmodule

// File: tb/tb_mm_dispatch.sv
// tb/tb_mm_dispatch.sv - randomized self-checking bench for mm_dispatch against a transaction-level model
module tb_mm_dispatch;

    logic         clk = 1'b0;
    logic         rstn;
    logic         instr_valid;
    logic         instr_ready;
    logic [127:0] instr_data;
    logic         start_valid;
    logic [12:0]  weight_start_addr;
    logic [10:0]  input_start_addr;
    logic [10:0]  output_start_addr;
    logic [7:0]   input_addr_per_feature;
    logic [7:0]   output_addr_per_feature;
    logic [15:0]  number_of_node;
    logic [8:0]   bias_start_addr;
    logic         r, a, b;
    logic         done;
    logic         busy;
    logic         cmpl_valid;
    logic [1:0]   cmpl_status;

    int tests_run = 0;
    int tests_failed = 0;

    mm_dispatch #(.OPCODE_MM(4'h2), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rstn(rstn),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .start_valid(start_valid),
        .weight_start_addr(weight_start_addr), .input_start_addr(input_start_addr),
        .output_start_addr(output_start_addr),
        .input_addr_per_feature(input_addr_per_feature),
        .output_addr_per_feature(output_addr_per_feature),
        .number_of_node(number_of_node), .bias_start_addr(bias_start_addr),
        .r(r), .a(a), .b(b),
        .done(done), .busy(busy), .cmpl_valid(cmpl_valid), .cmpl_status(cmpl_status)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [3:0] op, input logic [7:0] ci,
                                        input logic [7:0] co, input logic [15:0] n);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        v[3:0]   = op;
        v[46:39] = ci;
        v[54:47] = co;
        v[70:55] = n;
        return v;
    endfunction

    // Observed parameter outputs, packed in instruction bit order [82:4]
    function automatic logic [78:0] obs_fields();
        return {b, a, r, bias_start_addr, number_of_node, output_addr_per_feature,
                input_addr_per_feature, output_start_addr, input_start_addr, weight_start_addr};
    endfunction

    function automatic logic [127:0] all_outs();
        return {obs_fields(), start_valid, cmpl_valid, cmpl_status, busy, instr_ready};
    endfunction

    // One dispatch: accept, optional start, done after dly BUSY cycles, completion.
    task automatic txn(input logic [127:0] ins, input int dly, input bit done_in_start,
                       input bit hold, input logic [127:0] nxt);
        bit          ok;
        logic [78:0] f;
        int          n;
        ok = (ins[3:0] == 4'h2) && (ins[46:39] != 0) && (ins[54:47] != 0) && (ins[70:55] != 0);
        f  = ins[82:4];
        n  = 0;
        while (!instr_ready && n < 100) begin
            step();
            n++;
        end
        check("ready_before_accept", instr_ready, 1);
        instr_data  = ins;
        instr_valid = 1'b1;
        step();
        if (hold) instr_data = nxt;
        else instr_valid = 1'b0;
        check("fields_after_accept", obs_fields(), f);
        check("ready_low_after_accept", instr_ready, 0);
        check("busy_after_accept", busy, 1);
        if (ok) begin
            check("start_pulse", start_valid, 1);
            check("no_cmpl_in_start", cmpl_valid, 0);
            if (done_in_start) done = 1'b1;
            step();
            done = 1'b0;
            for (int i = 0; i < dly; i++) begin
                check("start_once", start_valid, 0);
                check("busy_no_cmpl", cmpl_valid, 0);
                check("busy_ready_low", instr_ready, 0);
                check("busy_fields_stable", obs_fields(), f);
                step();
            end
            check("start_once_end", start_valid, 0);
            check("no_early_cmpl", cmpl_valid, 0);
            done = 1'b1;
            step();
            done = 1'b0;
            check("cmpl_pulse_ok", cmpl_valid, 1);
            check("status_ok", cmpl_status, 2'b00);
        end else begin
            check("reject_no_start", start_valid, 0);
            check("reject_cmpl_pulse", cmpl_valid, 1);
            check("status_rejected", cmpl_status, 2'b01);
        end
        check("cmpl_fields_stable", obs_fields(), f);
        check("cmpl_busy", busy, 1);
        step();
        check("cmpl_single", cmpl_valid, 0);
        check("ready_after_cmpl", instr_ready, 1);
        check("idle_not_busy", busy, 0);
        check("no_start_idle", start_valid, 0);
        check("status_held", cmpl_status, ok ? 2'b00 : 2'b01);
        check("idle_fields_held", obs_fields(), f);
    endtask

    logic [127:0] ins_a, ins_b, ins_r;
    int           dly;
    logic [3:0]   op;
    logic [7:0]   ci, co;
    logic [15:0]  nn;

    initial begin
        rstn = 1'b0; instr_valid = 1'b0; done = 1'b0; instr_data = '0;
        step();
        step();
        check("reset_outputs", all_outs(), 0);
        rstn = 1'b1;
        step();
        check("ready_first_edge", instr_ready, 1);
        check("idle_busy_low", busy, 0);

        // done while idle must not disturb anything
        done = 1'b1;
        step();
        done = 1'b0;
        check("done_idle_ready", instr_ready, 1);
        check("done_idle_busy", busy, 0);
        check("done_idle_cmpl", cmpl_valid, 0);

        // Ci=4 Co=2 N=3, done at T+30, with new fields held on instr_valid throughout
        ins_a = mk(4'h2, 8'd4, 8'd2, 16'd3);
        ins_b = mk(4'h2, 8'd7, 8'd1, 16'd9);
        txn(ins_a, 28, 1'b1, 1'b1, ins_b);
        txn(ins_b, 3, 1'b0, 1'b0, '0);

        // rejects: bad opcode, then N=0
        txn(mk(4'h5, 8'd4, 8'd2, 16'd3), 0, 1'b0, 1'b0, '0);
        txn(mk(4'h2, 8'd4, 8'd2, 16'd0), 0, 1'b0, 1'b0, '0);

        for (int k = 0; k < 24; k++) begin
            op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h2;
            ci  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            co  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            nn  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            dly = $urandom_range(0, 10);
            txn(mk(op, ci, co, nn), dly, 1'($urandom), 1'b0, '0);
        end

        // reset while BUSY
        ins_r = mk(4'h2, 8'd1, 8'd1, 16'd1);
        instr_data = ins_r; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        check("busy_before_reset", busy, 1);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        step();
        rstn = 1'b1;
        step();
        check("ready_after_release", instr_ready, 1);
        check("busy_after_release", busy, 0);

`ifdef MM_DISPATCH_TIMEOUT_EN
        instr_data = mk(4'h2, 8'd4, 8'd2, 16'd3); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check("to_start", start_valid, 1);
        step();
        for (int i = 0; i < 16; i++) begin
            check("to_no_early_cmpl", cmpl_valid, 0);
            step();
        end
        check("to_cmpl_pulse", cmpl_valid, 1);
        check("to_status", cmpl_status, 2'b10);
        instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("halt_ready_low", instr_ready, 0);
            check("halt_no_cmpl", cmpl_valid, 0);
            check("halt_busy", busy, 1);
        end
        instr_valid = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("halt_exit_reset", instr_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
